// File: rtl/load_data_seq.sv
// Loads one byte of a fixed pattern into a 74HC595-style shift register per frame strobe:
// clear (MR), shift MSB-first (DS/SHCP), latch (STCP), then flag completion.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; waiting for the first frame start
// CLEAR | MR low for one slot to clear the external shift register
// SHIFT | one slot per bit, bit 7..0; SHCP rises mid-slot
// LATCH | STCP high for the first half slot, low for the second
// DONE  | finish high; byte index already advanced; waiting for start
module load_data_seq #(
    parameter int          CLK_DIV = 10,
    parameter int          SEQ_LEN = 8,
    parameter logic [63:0] PATTERN = 64'h8040201008040201
) (
    input  logic master_clk,
    input  logic manual_reset,
    input  logic frame_clk,
    output logic DS,
    output logic SHCP,
    output logic STCP,
    output logic MR,
    output logic finish
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [2:0]       IDX_LAST = 3'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       frame_sync_q, frame_sync_d;
    logic             ds_q, ds_d;
    logic             shcp_q, shcp_d;
    logic             stcp_q, stcp_d;
    logic             mr_q, mr_d;
    logic             finish_q, finish_d;

    logic             start;
    logic             slot_end;
    logic [7:0]       cur_byte;

    // [0] metastability flop, [1] synchronized level, [2] previous level for edge detect
    always_comb begin
        frame_sync_d = {frame_sync_q[1:0], frame_clk};
    end

    assign start    = frame_sync_q[1] & ~frame_sync_q[2];
    assign slot_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (slot_end) begin
                    state_d = S_SHIFT;
                    bit_d   = 3'd7;
                end
            end
            S_SHIFT: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_LATCH: begin
                if (slot_end) begin
                    state_d = S_DONE;
                    idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so that every pin is a flop
    // and changes in the same cycle as the state/counter it belongs to.
    always_comb begin
        cur_byte = 8'(PATTERN >> {idx_d, 3'b000});
        ds_d     = (state_d == S_SHIFT) & cur_byte[bit_d];
        shcp_d   = (state_d == S_SHIFT) && (cnt_d >= CNT_HALF);
        stcp_d   = (state_d == S_LATCH) && (cnt_d < CNT_HALF);
        mr_d     = (state_d != S_CLEAR);
        finish_d = (state_d == S_DONE);
    end

    // manual_reset is expected to be released synchronously to master_clk upstream.
    always_ff @(posedge master_clk or negedge manual_reset) begin
        if (!manual_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd7;
            idx_q        <= 3'd0;
            frame_sync_q <= 3'b000;
            ds_q         <= 1'b0;
            shcp_q       <= 1'b0;
            stcp_q       <= 1'b0;
            mr_q         <= 1'b1;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            frame_sync_q <= frame_sync_d;
            ds_q         <= ds_d;
            shcp_q       <= shcp_d;
            stcp_q       <= stcp_d;
            mr_q         <= mr_d;
            finish_q     <= finish_d;
        end
    end

    assign DS     = ds_q;
    assign SHCP   = shcp_q;
    assign STCP   = stcp_q;
    assign MR     = mr_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_load_data_seq.sv
// Bench for load_data_seq: randomized frame strobes, a pin-level 74HC595 model
// capturing what would be latched, and expectations derived from the pattern table.
module tb_load_data_seq;

    localparam int          CLK_DIV = 10;
    localparam int          HALF    = CLK_DIV / 2;
    localparam int          SEQ_LEN = 8;
    localparam logic [63:0] PAT0    = 64'h8040201008040201;
    localparam logic [63:0] PAT1    = 64'h8040201008040269;

    logic master_clk = 1'b0;
    logic manual_reset;
    logic frame_clk;
    logic ds, shcp, stcp, mr, fin;
    logic ds1, shcp1, stcp1, mr1, fin1;

    int n_checks = 0;
    int n_fail   = 0;
    int model_idx = 0;

    always #5 master_clk = ~master_clk;

    load_data_seq #(.CLK_DIV(CLK_DIV), .SEQ_LEN(SEQ_LEN), .PATTERN(PAT0)) dut (
        .master_clk  (master_clk),
        .manual_reset(manual_reset),
        .frame_clk   (frame_clk),
        .DS          (ds),
        .SHCP        (shcp),
        .STCP        (stcp),
        .MR          (mr),
        .finish      (fin)
    );

    load_data_seq #(.CLK_DIV(CLK_DIV), .SEQ_LEN(SEQ_LEN), .PATTERN(PAT1)) dut_custom (
        .master_clk  (master_clk),
        .manual_reset(manual_reset),
        .frame_clk   (frame_clk),
        .DS          (ds1),
        .SHCP        (shcp1),
        .STCP        (stcp1),
        .MR          (mr1),
        .finish      (fin1)
    );

    // Pin-level observer of the default instance, sampled on the falling clock edge.
    int         cyc = 0;
    logic       p_shcp = 0, p_stcp = 0, p_mr = 1, p_fin = 0, p_ds = 0;
    int         shcp_edges = 0, last_shcp = 0, spacing_err = 0, overlap_err = 0, ds_unstable = 0;
    int         mr_fall_cyc = 0, mr_rise_cyc = 0, mr_low_len = 0, mr_falls = 0;
    int         stcp_rise_cyc = 0, stcp_len = 0, fin_delay = 0, fin_count = 0, frames = 0, first_off = 0;
    logic       fin_at_clear = 0;
    logic [7:0] sreg = 0, latched = 0;

    always @(negedge master_clk) begin
        cyc++;
        if (p_mr && !mr) begin
            mr_fall_cyc  = cyc;
            mr_falls++;
            shcp_edges   = 0;
            spacing_err  = 0;
            overlap_err  = 0;
            ds_unstable  = 0;
            fin_at_clear = fin;
        end
        if (!mr) sreg = 8'h00;
        if (!p_mr && mr) begin
            mr_rise_cyc = cyc;
            mr_low_len  = cyc - mr_fall_cyc;
        end
        if (!p_shcp && shcp) begin
            if (shcp_edges == 0) first_off = cyc - mr_rise_cyc;
            else if (cyc - last_shcp != CLK_DIV) spacing_err++;
            last_shcp = cyc;
            sreg = {sreg[6:0], ds};
            shcp_edges++;
        end
        if (shcp && p_shcp && ds != p_ds) ds_unstable++;
        if (shcp && stcp) overlap_err++;
        if (!p_stcp && stcp) begin
            stcp_rise_cyc = cyc;
            latched = sreg;
            frames++;
        end
        if (p_stcp && !stcp) stcp_len = cyc - stcp_rise_cyc;
        if (!p_fin && fin) begin
            fin_delay = cyc - mr_fall_cyc;
            fin_count++;
        end
        p_shcp = shcp; p_stcp = stcp; p_mr = mr; p_fin = fin; p_ds = ds;
    end

    logic       p_shcp1 = 0, p_stcp1 = 0;
    logic [7:0] sreg1 = 0, latched1 = 0;
    always @(negedge master_clk) begin
        if (!mr1) sreg1 = 8'h00;
        if (!p_shcp1 && shcp1) sreg1 = {sreg1[6:0], ds1};
        if (!p_stcp1 && stcp1) latched1 = sreg1;
        p_shcp1 = shcp1; p_stcp1 = stcp1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge master_clk);
        #1;
    endtask

    function automatic logic [7:0] model_byte(input logic [63:0] pat, input int idx);
        return pat[8*idx +: 8];
    endfunction

    task automatic raise_frame(output int rc);
        tick();
        #($urandom_range(0, 2));
        frame_clk = 1'b1;
        rc = cyc;
    endtask

    task automatic wait_fin(input int fin0, input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (fin_count != fin0) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int rc, input int fr0);
        logic [7:0] exp_byte;
        exp_byte = model_byte(PAT0, model_idx);
        model_idx = (model_idx + 1) % SEQ_LEN;
        chk({tag, "_byte"},      32'(latched), 32'(exp_byte));
        chk({tag, "_frames"},    32'(frames - fr0), 32'd1);
        chk({tag, "_shcp_cnt"},  32'(shcp_edges), 32'd8);
        chk({tag, "_mr_low"},    32'(mr_low_len), 32'(CLK_DIV));
        chk({tag, "_stcp_len"},  32'(stcp_len), 32'(HALF));
        chk({tag, "_fin_delay"}, 32'(fin_delay), 32'(10 * CLK_DIV));
        chk({tag, "_first_shcp"}, 32'(first_off), 32'(HALF));
        chk({tag, "_spacing"},   32'(spacing_err), 32'd0);
        chk({tag, "_overlap"},   32'(overlap_err), 32'd0);
        chk({tag, "_ds_stable"}, 32'(ds_unstable), 32'd0);
        chk({tag, "_fin_clear"}, 32'(fin_at_clear), 32'd0);
        chk({tag, "_latency_ok"}, 32'((mr_fall_cyc - rc) >= 1 && (mr_fall_cyc - rc) <= 3), 32'd1);
        chk({tag, "_fin_level"}, 32'(fin), 32'd1);
    endtask

    task automatic do_frame(input string tag);
        int rc, fin0, fr0;
        fin0 = fin_count;
        fr0  = frames;
        raise_frame(rc);
        repeat ($urandom_range(3, 40)) tick();
        frame_clk = 1'b0;
        wait_fin(fin0, {tag, "_timeout"});
        check_frame(tag, rc, fr0);
    endtask

    initial begin
        int rst_bad;
        int rc, fin0, fr0, mf0;
        bit ok;

        manual_reset = 1'b1;
        frame_clk    = 1'b0;
        #3 manual_reset = 1'b0;

        rst_bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i % 7 == 3) frame_clk = ~frame_clk;
            if ({ds, shcp, stcp, mr, fin} != 5'b00010) rst_bad++;
            if ({ds1, shcp1, stcp1, mr1, fin1} != 5'b00010) rst_bad++;
        end
        chk("rst_outs", 32'(rst_bad), 32'd0);
        chk("rst_mr", 32'(mr), 32'd1);
        chk("rst_no_frame", 32'(mr_falls), 32'd0);

        frame_clk = 1'b0;
        tick();
        manual_reset = 1'b1;
        repeat (20) tick();
        chk("idle_no_frame", 32'(mr_falls), 32'd0);
        chk("idle_fin", 32'(fin), 32'd0);

        do_frame("f0");
        chk("custom_pattern", 32'(latched1), 32'(model_byte(PAT1, 0)));
        for (int f = 1; f < 9; f++) begin
            repeat ($urandom_range(20, 300)) tick();
            do_frame($sformatf("f%0d", f));
        end

        // A second strobe edge arriving 40 cycles into SHIFT must be dropped.
        repeat ($urandom_range(20, 100)) tick();
        fin0 = fin_count; fr0 = frames; mf0 = mr_falls;
        raise_frame(rc);
        repeat (5) tick();
        frame_clk = 1'b0;
        while (cyc < rc + 3 + CLK_DIV + 40) tick();
        frame_clk = 1'b1;
        repeat (5) tick();
        frame_clk = 1'b0;
        wait_fin(fin0, "busy_timeout");
        check_frame("busy", rc, fr0);
        repeat (150) tick();
        chk("busy_one_frame", 32'(frames - fr0), 32'd1);
        chk("busy_one_clear", 32'(mr_falls - mf0), 32'd1);
        chk("busy_fin_held", 32'(fin), 32'd1);
        do_frame("after_busy");

        // Reset in the middle of SHIFT abandons the frame and rewinds the index.
        repeat ($urandom_range(20, 100)) tick();
        mf0 = mr_falls;
        raise_frame(rc);
        repeat (5) tick();
        frame_clk = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (mr_falls != mf0 && shcp_edges == 3) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("midrst_reach_shift", 32'(ok), 32'd1);
        repeat (2) tick();
        manual_reset = 1'b0;
        #1;
        chk("midrst_outs", 32'({ds, shcp, stcp, mr, fin}), 32'b00010);
        chk("midrst_outs_custom", 32'({ds1, shcp1, stcp1, mr1, fin1}), 32'b00010);
        repeat (5) tick();
        chk("midrst_outs_hold", 32'({ds, shcp, stcp, mr, fin}), 32'b00010);
        manual_reset = 1'b1;
        repeat (5) tick();
        model_idx = 0;
        do_frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_data_seq.md
Name: load_data_seq

Overview:
- Drives a 74HC595-style serial-in/parallel-out shift register from a fixed internal sequence of bytes.
- On each rising edge of the frame strobe it performs one complete load of the next byte:
  - clear the register (MR pulse),
  - shift the byte out MSB-first on DS/SHCP,
  - latch it to the outputs (STCP pulse),
  - flag completion.
- Serial timing comes from an internal frequency divider implemented as an enable, so the whole block runs in the master_clk domain. It sits between the frame timer and the external shift-register pins.

Parameters:
- CLK_DIV, 10, master_clk cycles per serial bit slot; even, >=2; HALF = CLK_DIV/2.
- SEQ_LEN, 8, number of bytes in the sequence; 1..8.
- PATTERN, 64'h8040201008040201, byte i = PATTERN[8i+7:8i]; byte 0 = 8'h01.

Ports:
- master_clk, input, 1, sole clock; all logic on the rising edge.
- manual_reset, input, 1, asynchronous active-low reset; also wired to the shift register's active-low OE.
- frame_clk, input, 1, asynchronous frame strobe; sampled as data, never used as a clock.
- DS, output, 1, serial data to the shift register.
- SHCP, output, 1, shift clock.
- STCP, output, 1, storage/latch clock.
- MR, output, 1, active-low master reset to the shift register.
- finish, output, 1, high once a frame load has completed.

Behaviour:
- Reset (manual_reset=0, asynchronous; released synchronously to master_clk):
  - State IDLE, byte index 0, divider counter 0, bit counter 7.
  - Outputs: DS=0, SHCP=0, STCP=0, MR=1, finish=0.
  - Synchronizer flops cleared.
- Frame detect:
  - frame_clk passes through a 2-flop synchronizer plus an edge register.
  - A rising edge produces a 1-cycle start pulse.
  - The FSM leaves IDLE or DONE no later than 3 master_clk cycles after the input edge.
- Divider: counter 0..CLK_DIV-1, cleared on every state entry.
  - Half-tick at count HALF-1.
  - Slot-end tick at count CLK_DIV-1.
- FSM states and transitions:
  - IDLE: waits for start, then goes to CLEAR.
  - CLEAR: MR=0 for CLK_DIV cycles; finish=0. Then goes to SHIFT with the bit counter at 7.
  - SHIFT: one slot of CLK_DIV cycles per bit, MSB first (bit 7..0).
    - DS = byte[index][bit] for the entire slot.
    - SHCP=0 for the first HALF cycles, 1 for the last HALF cycles, so the rising edge lands mid-slot with DS stable HALF cycles before and after.
    - After bit 0's slot, goes to LATCH with SHCP=0.
  - LATCH: STCP=1 for HALF cycles, then 0 for HALF cycles; DS=0. Then goes to DONE.
  - DONE: finish=1. Byte index increments once on entry, wrapping SEQ_LEN-1 -> 0. Waits for start, then goes to CLEAR.
- Frame duration: exactly 10*CLK_DIV cycles from CLEAR entry to DONE entry (100 at default).
- Start pulses arriving in CLEAR, SHIFT or LATCH are ignored and not queued.
- MR is high in every state except CLEAR.
- SHCP and STCP are never high simultaneously.
- All outputs are registered and glitch-free.
- Reset mid-frame: outputs return to their reset values immediately; the frame is abandoned; the index returns to 0.

Test Plan:
- Reset values: hold manual_reset=0 with frame_clk toggling -> DS=0, SHCP=0, STCP=0, MR=1, finish=0 throughout; the FSM never leaves IDLE.
- First frame at defaults:
  - Release reset, raise frame_clk -> MR low for 10 cycles.
  - Then 8 SHCP rising edges spaced 10 cycles apart, with DS sampled at those edges = 0,0,0,0,0,0,0,1.
  - Then an STCP high pulse of 5 cycles.
  - finish rises 100 cycles after MR falls.
- Sequence and wrap:
  - Frame_clk period 5400 cycles, 9 frames -> latched bytes 01,02,04,08,10,20,40,80,01.
  - finish drops on each new CLEAR.
- Custom pattern: PATTERN byte0=8'h69 -> DS bits at SHCP edges = 0,1,1,0,1,0,0,1.
- Busy frame edge: a second frame_clk rising edge 40 cycles into SHIFT -> ignored; exactly 8 SHCP edges; a single frame; the index advances by 1 only.
- Reset mid-shift: drop manual_reset after 3 SHCP edges -> all outputs go to reset values asynchronously. The next frame after release loads byte 0 (8'h01).
